// File: rtl/cic_d_mc.sv
// Multi-channel time-multiplexed CIC decimator: shared integrator chain and comb datapath.
// Define CIC_D_MC_SAT_EN to saturate the output instead of truncating to OUT_DW.
module cic_d_mc #(
    parameter int INP_DW    = 18,
    parameter int OUT_DW    = 18,
    parameter int CIC_NCH   = 4,
    parameter int CIC_R_MAX = 64,
    parameter int CIC_N     = 5,
    parameter int CIC_M     = 1,
    parameter int ACC_DW    = INP_DW + CIC_N * $clog2(CIC_R_MAX * CIC_M)
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          clear,
    input  logic [$clog2(CIC_R_MAX+1)-1:0]                cic_r,
    input  logic [$clog2(ACC_DW)-1:0]                     out_shift,
    input  logic [INP_DW-1:0]                             inp_samp_data,
    input  logic [((CIC_NCH > 1) ? $clog2(CIC_NCH) : 1)-1:0] inp_samp_ch,
    input  logic                                          inp_samp_str,
    output logic [OUT_DW-1:0]                             out_samp_data,
    output logic [((CIC_NCH > 1) ? $clog2(CIC_NCH) : 1)-1:0] out_samp_ch,
    output logic                                          out_samp_str,
    output logic                                          ovf
);

    localparam int RW = $clog2(CIC_R_MAX + 1);
    localparam int CW = (CIC_NCH > 1) ? $clog2(CIC_NCH) : 1;
    localparam int KW = (CIC_N > 1) ? $clog2(CIC_N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COMB, S_OUT} state_t;

    logic [ACC_DW-1:0] integ_q [CIC_NCH][CIC_N];
    logic [ACC_DW-1:0] integ_d [CIC_NCH][CIC_N];
    logic [ACC_DW-1:0] dly_q   [CIC_NCH][CIC_N][CIC_M];
    logic [ACC_DW-1:0] dly_d   [CIC_NCH][CIC_N][CIC_M];
    logic [RW-1:0]     cnt_q   [CIC_NCH];
    logic [RW-1:0]     cnt_d   [CIC_NCH];

    logic [RW-1:0]     r_q, r_d, r_clamp;
    logic              dec_q, dec_d;
    logic [CW-1:0]     dch_q, dch_d;
    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     cch_q, cch_d;
    logic [ACC_DW-1:0] x_q, x_d;
    logic [OUT_DW-1:0] od_q, od_d;
    logic [CW-1:0]     och_q, och_d;
    logic              ostr_q, ostr_d;
    logic              ovf_q, ovf_d;
    logic [ACC_DW-1:0] acc, y;
    logic              inp_ok;

    assign inp_ok = inp_samp_str && (32'(inp_samp_ch) < CIC_NCH);

    always_comb begin
        if (cic_r < RW'(2))
            r_clamp = RW'(2);
        else if (cic_r > RW'(CIC_R_MAX))
            r_clamp = RW'(CIC_R_MAX);
        else
            r_clamp = cic_r;
    end

    // Integrators and decimation counters of the strobed channel
    always_comb begin
        integ_d = integ_q;
        cnt_d   = cnt_q;
        dec_d   = 1'b0;
        dch_d   = dch_q;
        r_d     = r_q;
        acc     = '0;
        if (clear) begin
            for (int c = 0; c < CIC_NCH; c++) begin
                cnt_d[c] = '0;
                for (int k = 0; k < CIC_N; k++)
                    integ_d[c][k] = '0;
            end
            r_d   = r_clamp;
            dch_d = '0;
        end else if (inp_ok) begin
            acc = {{(ACC_DW-INP_DW){inp_samp_data[INP_DW-1]}}, inp_samp_data};
            for (int k = 0; k < CIC_N; k++) begin
                acc = acc + integ_q[inp_samp_ch][k];
                integ_d[inp_samp_ch][k] = acc;
            end
            if (cnt_q[inp_samp_ch] == r_q - RW'(1)) begin
                cnt_d[inp_samp_ch] = '0;
                dec_d = 1'b1;
                dch_d = inp_samp_ch;
            end else begin
                cnt_d[inp_samp_ch] = cnt_q[inp_samp_ch] + RW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dec_q) state_d = S_COMB;
            S_COMB:  if (k_q == KW'(CIC_N - 1)) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear)
            state_d = S_IDLE;
    end

`ifdef CIC_D_MC_SAT_EN
    logic [ACC_DW-1:0]   sh;
    logic [ACC_DW-OUT_DW:0] sh_hi;
    assign sh    = $signed(x_q) >>> out_shift;
    assign sh_hi = sh[ACC_DW-1:OUT_DW-1];
`endif

    always_comb begin
        dly_d  = dly_q;
        x_d    = x_q;
        k_d    = k_q;
        cch_d  = cch_q;
        od_d   = od_q;
        och_d  = och_q;
        ostr_d = 1'b0;
        ovf_d  = ovf_q;
        y      = '0;
        if (clear) begin
            for (int c = 0; c < CIC_NCH; c++)
                for (int k = 0; k < CIC_N; k++)
                    for (int j = 0; j < CIC_M; j++)
                        dly_d[c][k][j] = '0;
            x_d   = '0;
            k_d   = '0;
            cch_d = '0;
            od_d  = '0;
            och_d = '0;
            ovf_d = 1'b0;
        end else begin
            // A decimation event arriving while busy is lost
            if (dec_q) begin
                if (state_q == S_IDLE) begin
                    x_d   = integ_q[dch_q][CIC_N-1];
                    cch_d = dch_q;
                    k_d   = '0;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (state_q == S_COMB) begin
                y = x_q - dly_q[cch_q][k_q][CIC_M-1];
                for (int j = CIC_M - 1; j > 0; j--)
                    dly_d[cch_q][k_q][j] = dly_q[cch_q][k_q][j-1];
                dly_d[cch_q][k_q][0] = x_q;
                x_d = y;
                k_d = k_q + KW'(1);
            end
            if (state_q == S_OUT) begin
`ifdef CIC_D_MC_SAT_EN
                if ((&sh_hi) || !(|sh_hi))
                    od_d = sh[OUT_DW-1:0];
                else if (sh[ACC_DW-1])
                    od_d = {1'b1, {(OUT_DW-1){1'b0}}};
                else
                    od_d = {1'b0, {(OUT_DW-1){1'b1}}};
`else
                od_d = OUT_DW'($signed(x_q) >>> out_shift);
`endif
                och_d  = cch_q;
                ostr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CIC_NCH; c++) begin
                cnt_q[c] <= '0;
                for (int k = 0; k < CIC_N; k++) begin
                    integ_q[c][k] <= '0;
                    for (int j = 0; j < CIC_M; j++)
                        dly_q[c][k][j] <= '0;
                end
            end
            r_q    <= RW'(CIC_R_MAX);
            dec_q  <= 1'b0;
            dch_q  <= '0;
            k_q    <= '0;
            cch_q  <= '0;
            x_q    <= '0;
            od_q   <= '0;
            och_q  <= '0;
            ostr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            dec_q   <= dec_d;
            dch_q   <= dch_d;
            k_q     <= k_d;
            cch_q   <= cch_d;
            x_q     <= x_d;
            od_q    <= od_d;
            och_q   <= och_d;
            ostr_q  <= ostr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    assign out_samp_data = od_q;
    assign out_samp_ch   = och_q;
    assign out_samp_str  = ostr_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_cic_d_mc.sv
// Directed bench for cic_d_mc; expected outputs come from an FIR-form CIC model.
module tb_cic_d_mc;

    localparam int INP_DW = 18;
    localparam int OUT_DW = 18;
    localparam int NCH    = 4;
    localparam int RMAX   = 16;
    localparam int N      = 3;
    localparam int M      = 1;
    localparam int ACC_DW = INP_DW + N * $clog2(RMAX * M);

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              clear = 1'b0;
    logic [4:0]        cic_r = '0;
    logic [4:0]        out_shift = '0;
    logic [17:0]       inp_samp_data = '0;
    logic [1:0]        inp_samp_ch = '0;
    logic              inp_samp_str = 1'b0;
    logic [17:0]       out_samp_data;
    logic [1:0]        out_samp_ch;
    logic              out_samp_str;
    logic              ovf;

    cic_d_mc #(
        .INP_DW(INP_DW), .OUT_DW(OUT_DW), .CIC_NCH(NCH),
        .CIC_R_MAX(RMAX), .CIC_N(N), .CIC_M(M)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .cic_r(cic_r), .out_shift(out_shift),
        .inp_samp_data(inp_samp_data), .inp_samp_ch(inp_samp_ch),
        .inp_samp_str(inp_samp_str),
        .out_samp_data(out_samp_data), .out_samp_ch(out_samp_ch),
        .out_samp_str(out_samp_str), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     ch;
        longint data;
        int     cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     out_cnt = 0;
    longint last_data[NCH];
    longint h[64];
    longint hist[NCH][64];
    int     cnt_m[NCH];
    int     r_m = RMAX;
    int     sh_m = 0;
    int     last_acc = -100;
    int     n0;
    int     vals[NCH] = '{1, -1, 2, 0};

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void calc_h(input int r);
        longint a[64];
        longint b[64];
        int len;
        foreach (a[i]) a[i] = 0;
        a[0] = 1;
        len = 1;
        for (int s = 0; s < N; s++) begin
            foreach (b[i]) b[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < r * M; j++)
                    b[i+j] += a[i];
            len += r * M - 1;
            a = b;
        end
        h = a;
    endfunction

`ifdef CIC_D_MC_SAT_EN
    function automatic longint reduce(input longint y);
        longint mx;
        mx = (longint'(1) <<< (OUT_DW - 1)) - 1;
        if (y > mx) return mx;
        if (y < -mx - 1) return -mx - 1;
        return y;
    endfunction
`else
    function automatic longint reduce(input longint y);
        logic signed [OUT_DW-1:0] t;
        t = y[OUT_DW-1:0];
        return longint'(t);
    endfunction
`endif

    function automatic void model_reset(input int r, input int sh);
        for (int c = 0; c < NCH; c++) begin
            cnt_m[c] = 0;
            for (int i = 0; i < 64; i++) hist[c][i] = 0;
        end
        r_m = r;
        sh_m = sh;
        calc_h(r);
        exp_q.delete();
        last_acc = -100;
    endfunction

    task automatic strobe(input int ch, input int d, input int idle);
        longint y;
        logic signed [ACC_DW-1:0] w;
        exp_t e;
        inp_samp_ch   = 2'(ch);
        inp_samp_data = 18'(d);
        inp_samp_str  = 1'b1;
        for (int i = 63; i > 0; i--) hist[ch][i] = hist[ch][i-1];
        hist[ch][0] = d;
        if (cnt_m[ch] == r_m - 1) begin
            cnt_m[ch] = 0;
            if (cyc - last_acc >= N + 3) begin
                y = 0;
                for (int i = 0; i < 64; i++) y += h[i] * hist[ch][i];
                w = y[ACC_DW-1:0];
                e.ch   = ch;
                e.data = reduce(longint'(w) >>> sh_m);
                e.cyc  = cyc;
                exp_q.push_back(e);
                last_acc = cyc;
            end
        end else begin
            cnt_m[ch]++;
        end
        step();
        inp_samp_str = 1'b0;
        repeat (idle) step();
    endtask

    task automatic do_clear(input int cr, input int reff, input int sh);
        cic_r     = 5'(cr);
        out_shift = 5'(sh);
        clear     = 1'b1;
        step();
        clear = 1'b0;
        model_reset(reff, sh);
        chk("clr_ovf", ovf, 0);
        chk("clr_str", out_samp_str, 0);
        chk("clr_data", out_samp_data, 0);
    endtask

    task automatic drain();
        repeat (N + 8) step();
        chk("drained", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && out_samp_str) begin
            out_cnt++;
            last_data[out_samp_ch] = $signed(out_samp_data);
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_ch", out_samp_ch, e.ch);
                chk("out_data", $signed(out_samp_data), e.data);
                chk("latency", cyc, e.cyc + N + 3);
            end
        end
    end

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) step();
        chk("rst_data", out_samp_data, 0);
        chk("rst_ch", out_samp_ch, 0);
        chk("rst_str", out_samp_str, 0);
        chk("rst_ovf", ovf, 0);
        reset_n = 1'b1;
        model_reset(RMAX, 0);
        step();

        // single channel DC, R=4
        do_clear(4, 4, 0);
        n0 = out_cnt;
        for (int i = 0; i < 16; i++) strobe(0, 5, 7);
        drain();
        chk("t1_count", out_cnt - n0, 4);
        chk("t1_dc", last_data[0], 320);

        // four interleaved channels, R=8
        do_clear(8, 8, 0);
        n0 = out_cnt;
        for (int r = 0; r < 40; r++)
            for (int c = 0; c < NCH; c++) strobe(c, vals[c], 5);
        drain();
        chk("t2_count", out_cnt - n0, 20);
        chk("t2_ch0", last_data[0], 512);
        chk("t2_ch1", last_data[1], -512);
        chk("t2_ch2", last_data[2], 1024);
        chk("t2_ch3", last_data[3], 0);

        // collision two cycles apart
        do_clear(4, 4, 0);
        n0 = out_cnt;
        for (int i = 0; i < 3; i++) begin
            strobe(0, 100, 3);
            strobe(1, -50, 3);
        end
        strobe(0, 100, 1);
        strobe(1, -50, 10);
        drain();
        chk("t3_ovf", ovf, 1);
        chk("t3_count", out_cnt - n0, 1);
        do_clear(4, 4, 0);
        chk("t3_ovf_clr", ovf, 0);

        // ratio clamping
        do_clear(1, 2, 0);
        n0 = out_cnt;
        for (int i = 0; i < 10; i++) strobe(0, 3, 5);
        drain();
        chk("t4_rmin", out_cnt - n0, 5);
        do_clear(RMAX + 5, RMAX, 0);
        n0 = out_cnt;
        for (int i = 0; i < 32; i++) strobe(2, 3, 5);
        drain();
        chk("t4_rmax", out_cnt - n0, 2);

        // full-scale negative input, integrators wrap
        do_clear(4, 4, 0);
        for (int i = 0; i < 64; i++) strobe(0, -131072, 5);
        drain();
`ifdef CIC_D_MC_SAT_EN
        chk("t5_fs", last_data[0], -131072);
`else
        chk("t5_fs", last_data[0], 0);
`endif
        do_clear(4, 4, 6);
        for (int i = 0; i < 16; i++) strobe(3, 5, 5);
        drain();
        chk("t5_shift", last_data[3], 5);

        // reset in the middle of the comb sequence
        do_clear(4, 4, 0);
        for (int i = 0; i < 3; i++) strobe(0, 9, 5);
        strobe(0, 9, 2);
        n0 = out_cnt;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_data", out_samp_data, 0);
        chk("t6_rst_ch", out_samp_ch, 0);
        chk("t6_rst_str", out_samp_str, 0);
        chk("t6_rst_ovf", ovf, 0);
        step();
        reset_n = 1'b1;
        model_reset(RMAX, 0);
        repeat (15) step();
        chk("t6_rst_noout", out_cnt - n0, 0);

        // clear in the middle of the comb sequence, then new ratio
        do_clear(4, 4, 0);
        for (int i = 0; i < 3; i++) strobe(1, 9, 5);
        strobe(1, 9, 2);
        n0 = out_cnt;
        do_clear(2, 2, 0);
        repeat (10) step();
        chk("t6_clr_noout", out_cnt - n0, 0);
        n0 = out_cnt;
        for (int i = 0; i < 4; i++) strobe(1, 7, 5);
        drain();
        chk("t6_clr_count", out_cnt - n0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cic_d_mc.md
Name: cic_d_mc

Overview:
- Multi-channel, time-multiplexed CIC decimator with a runtime-programmable decimation ratio and a runtime output scaling shift.
- Successor to the single-channel fixed-ratio decimator: one shared integrator chain and one shared comb datapath serve CIC_NCH channels, with per-channel state held in register arrays.
- Sits between an ADC/DDC mixer producing interleaved channel samples and the downstream compensation FIR.

Parameters:
- INP_DW, 18: input sample width (signed).
- OUT_DW, 18: output sample width (signed).
- CIC_NCH, 4: number of channels (>=1).
- CIC_R_MAX, 64: largest supported decimation ratio (>=2).
- CIC_N, 5: number of integrator/comb stages.
- CIC_M, 1: comb differential delay (1 or 2).
- ACC_DW, INP_DW + CIC_N*clog2(CIC_R_MAX*CIC_M): internal width, no pruning.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  sync clear; zeroes all state, loads cic_r.
- cic_r  in  clog2(CIC_R_MAX+1)  decimation ratio; sampled only on clear.
- out_shift  in  clog2(ACC_DW)  arithmetic right shift applied to the comb result; sampled at output capture.
- inp_samp_data  in  INP_DW  signed input sample.
- inp_samp_ch  in  clog2(CIC_NCH) (min 1)  channel of the input sample.
- inp_samp_str  in  1  input strobe.
- out_samp_data  out  OUT_DW  signed decimated output.
- out_samp_ch  out  clog2(CIC_NCH) (min 1)  channel of the output.
- out_samp_str  out  1  one-cycle output strobe.
- ovf  out  1  sticky: decimated sample dropped because the comb was busy.

Behaviour:
- Reset (async) and clear (sync, priority over strobes):
  - Integrator, comb delay and per-channel decimation counter arrays, plus all outputs, go to 0; comb FSM goes to IDLE.
  - Reset loads r_reg=CIC_R_MAX; clear loads r_reg=cic_r, clamped to [2, CIC_R_MAX].
  - Reset or clear mid-comb aborts the sequence with no out_samp_str.
- Integrators:
  - On inp_samp_str with ch=inp_samp_ch, all CIC_N stages of channel ch update in that cycle.
  - Each stage's new value is the previous stage's new value plus its own old value; stage 0 adds the sign-extended input.
  - ACC_DW two's-complement arithmetic, modulo wrap-around; overflow is intentional.
  - inp_samp_ch >= CIC_NCH: strobe ignored entirely.
- Decimation:
  - Counter cnt[ch] increments on each strobe of ch and wraps to 0 at r_reg-1.
  - The strobe that wraps the counter is the decimation event: the last-stage integrator value after that update, together with ch, is captured into the comb holding register in the next cycle.
  - Channels are fully independent; strobes may arrive in any order or back to back.
- Comb FSM:
  - IDLE: on capture go to COMB with stage index k=0.
  - COMB: one stage per cycle, k=0..CIC_N-1. Each stage computes y = x - dly[ch][k][M-1], then shifts the delay line of channel ch.
  - After the last stage go to OUT, then return to IDLE.
- Output:
  - In OUT, out_samp_data = (comb result >>> out_shift), reduced to OUT_DW (see the Optional Feature). out_samp_ch is loaded in the same cycle; out_samp_str pulses high for exactly one cycle.
  - Data and channel hold until the next output.
  - Latency: a decimation strobe in cycle t gives out_samp_str in cycle t+CIC_N+3.
- Busy collision:
  - A decimation event while the FSM is not IDLE: that comb input is dropped and ovf is set.
  - Integrators and counters still update.
  - ovf clears only on reset or clear.
  - The guaranteed no-drop condition is decimation events spaced >= CIC_N+3 cycles apart.
- DC gain: (r_reg*CIC_M)^CIC_N, with out_shift compensating.

Optional Feature:
- CIC_D_MC_SAT_EN defined: if the shifted result exceeds the OUT_DW signed range, output saturates to +2^(OUT_DW-1)-1 or -2^(OUT_DW-1).
- Not defined: plain truncation to the OUT_DW LSBs (wraps).

Test Plan:
- NCH=1, clear with cic_r=4, N=3, M=1, out_shift=0, constant input 5 each strobe, strobes every 8 cycles -> after transient, outputs settle to 320 (5*64), one output per 4 strobes, latency exactly N+3 cycles from the 4th strobe.
- NCH=4, interleaved ch0..3 with DC values 1, -1, 2, 0, R=8 -> each channel settles to its value*512 on the matching out_samp_ch; channels stay independent.
- Two channels reach a decimation event 2 cycles apart -> second dropped, ovf=1, first output still correct; clear -> ovf=0.
- cic_r=1 and cic_r=CIC_R_MAX+5 on clear -> effective ratio 2 and CIC_R_MAX respectively (count outputs per strobes).
- Full-scale input -2^(INP_DW-1) with out_shift=0 -> with SAT_EN the output is -2^(OUT_DW-1); without SAT_EN it is the truncated LSBs. Integrator wrap yields the correct comb result.
- reset_n asserted mid-COMB -> no out_samp_str, all outputs 0; clear mid-COMB -> same, and new cic_r is used.
